// File: rtl/capsense_pkg.sv
// Shared types and constants for the capacitive-button event stage.
package capsense_pkg;

  // Event type codes as they appear on ev_type_o (3 is never produced).
  localparam logic [1:0] EV_PRESS   = 2'd0;
  localparam logic [1:0] EV_RELEASE = 2'd1;
  localparam logic [1:0] EV_LONG    = 2'd2;

  // Per-button debounce FSM states.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PDEB  = 3'd1,
    ST_HELD  = 3'd2,
    ST_LHELD = 3'd3,
    ST_RDEB  = 3'd4
  } btn_state_t;

  // Width of a button index; a single button still needs one bit.
  function automatic int unsigned btn_w(input int unsigned n);
    if (n > 1) return int'($clog2(n));
    else       return 1;
  endfunction

endpackage

// File: rtl/capsense_evfifo.sv
// Small synchronous event FIFO; push and pop may coincide, even when full.
module capsense_evfifo #(
  parameter int unsigned W     = 4,
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic [W-1:0] dout_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [AW:0]   r_cnt;
  logic          w_push;
  logic          w_pop;

  assign empty_o = (r_cnt == '0);
  assign full_o  = (r_cnt == (AW+1)'(DEPTH));
  assign w_pop   = pop_i && !empty_o;
  assign w_push  = push_i && (!full_o || w_pop);
  assign dout_o  = r_mem[r_rd];

  // Storage, pointers and occupancy count.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_mem <= '{default: '0};
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= din_i;
        r_wr        <= r_wr + AW'(1);
      end
      if (w_pop) r_rd <= r_rd + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
        2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/capsense_events.sv
// Per-button debounce, press/release/long-press detection and event queueing.
module capsense_events
  import capsense_pkg::*;
#(
  parameter int unsigned N     = 4,
  parameter int unsigned DEB   = 3,
  parameter int unsigned LONG  = 12,
  parameter int unsigned DEPTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [N-1:0]          buttons_i,
  input  logic                  sample_i,
  output logic [N-1:0]          state_o,
  output logic                  ev_valid_o,
  input  logic                  ev_ready_i,
  output logic [btn_w(N)-1:0]   ev_btn_o,
  output logic [1:0]            ev_type_o,
  output logic                  ovf_o,
  input  logic                  clr_ovf_i
);

  localparam int unsigned BW = btn_w(N);
  localparam int unsigned W  = BW + 2;

  logic [N-1:0][2:0] w_raise;
  logic [N-1:0][2:0] r_pend;
  logic [N-1:0][2:0] w_clr;
  logic [N-1:0][2:0] w_pend_nxt;
  logic              w_drop;
  logic              w_any;
  logic [BW-1:0]     w_sel_btn;
  logic [1:0]        w_sel_type;
  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic [W-1:0]      w_head;
  logic              r_ovf;

  for (genvar gi = 0; gi < int'(N); gi++) begin : g_btn
    btn_state_t r_st;
    btn_state_t r_ret;
    logic [3:0] r_deb;
    logic [7:0] r_hold;
    logic       r_held;
    logic       w_r;
    logic       w_deb_hit;
    logic       w_hold_hit;
    logic [2:0] w_rs;

    assign w_r        = buttons_i[gi];
    assign w_deb_hit  = (r_deb + 4'd1) == 4'(DEB);
    assign w_hold_hit = (r_hold + 8'd1) == 8'(LONG - DEB);
    assign w_raise[gi] = w_rs;
    assign state_o[gi] = r_held;

    // Decode which event this sample raises; a dip sample that returns to HELD counts toward LONG.
    always_comb begin
      w_rs = '0;
      if (sample_i) begin
        case (r_st)
          ST_IDLE:  w_rs[EV_PRESS] = w_r && (DEB == 1);
          ST_PDEB:  w_rs[EV_PRESS] = w_r && w_deb_hit;
          ST_HELD: begin
            w_rs[EV_LONG]    = w_r && w_hold_hit;
            w_rs[EV_RELEASE] = !w_r && (DEB == 1);
          end
          ST_LHELD: w_rs[EV_RELEASE] = !w_r && (DEB == 1);
          ST_RDEB: begin
            w_rs[EV_LONG]    = w_r && (r_ret == ST_HELD) && w_hold_hit;
            w_rs[EV_RELEASE] = !w_r && w_deb_hit;
          end
          default: ;
        endcase
      end
    end

    // Debounce FSM with its counters and the registered debounced state.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        r_st   <= ST_IDLE;
        r_ret  <= ST_IDLE;
        r_deb  <= '0;
        r_hold <= '0;
        r_held <= 1'b0;
      end else if (sample_i) begin
        case (r_st)
          ST_IDLE: if (w_r) begin
            if (DEB == 1) begin
              r_st   <= ST_HELD;
              r_hold <= '0;
              r_held <= 1'b1;
            end else begin
              r_st  <= ST_PDEB;
              r_deb <= 4'd1;
            end
          end
          ST_PDEB: begin
            if (!w_r) begin
              r_st  <= ST_IDLE;
              r_deb <= '0;
            end else if (w_deb_hit) begin
              r_st   <= ST_HELD;
              r_hold <= '0;
              r_held <= 1'b1;
            end else begin
              r_deb <= r_deb + 4'd1;
            end
          end
          ST_HELD, ST_LHELD: begin
            if (w_r) begin
              if (r_st == ST_HELD) begin
                r_hold <= r_hold + 8'd1;
                if (w_hold_hit) r_st <= ST_LHELD;
              end
            end else if (DEB == 1) begin
              r_st   <= ST_IDLE;
              r_held <= 1'b0;
            end else begin
              r_st  <= ST_RDEB;
              r_deb <= 4'd1;
              r_ret <= r_st;
            end
          end
          ST_RDEB: begin
            if (w_r) begin
              r_st <= r_ret;
              if (r_ret == ST_HELD) begin
                r_hold <= r_hold + 8'd1;
                if (w_hold_hit) r_st <= ST_LHELD;
              end
            end else if (w_deb_hit) begin
              r_st   <= ST_IDLE;
              r_deb  <= '0;
              r_held <= 1'b0;
            end else begin
              r_deb <= r_deb + 4'd1;
            end
          end
          default: r_st <= ST_IDLE;
        endcase
      end
    end
  end

  // Priority pick: lowest button first, then PRESS, LONG, RELEASE within a button.
  always_comb begin
    w_any      = 1'b0;
    w_sel_btn  = '0;
    w_sel_type = EV_PRESS;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (|r_pend[i]) begin
        w_any     = 1'b1;
        w_sel_btn = BW'(i);
        if (r_pend[i][EV_PRESS])     w_sel_type = EV_PRESS;
        else if (r_pend[i][EV_LONG]) w_sel_type = EV_LONG;
        else                         w_sel_type = EV_RELEASE;
      end
    end
  end

  assign w_pop  = !w_empty && ev_ready_i;
  assign w_push = w_any && (!w_full || w_pop);

  // Next pending flags: a new raise wins over a same-cycle push-clear; a raise onto a held flag is lost.
  always_comb begin
    w_clr = '0;
    if (w_push) w_clr[w_sel_btn][w_sel_type] = 1'b1;
    w_pend_nxt = w_raise | (r_pend & ~w_clr);
    w_drop     = |(w_raise & r_pend & ~w_clr);
  end

  // Pending flags and sticky overflow (set beats clear).
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_pend <= '0;
      r_ovf  <= 1'b0;
    end else begin
      r_pend <= w_pend_nxt;
      r_ovf  <= w_drop || (r_ovf && !clr_ovf_i);
    end
  end

  capsense_evfifo #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (w_push),
    .din_i   ({w_sel_btn, w_sel_type}),
    .pop_i   (w_pop),
    .dout_o  (w_head),
    .full_o  (w_full),
    .empty_o (w_empty)
  );

  assign ev_valid_o = !w_empty;
  assign ev_btn_o   = w_head[W-1:2];
  assign ev_type_o  = w_head[1:0];
  assign ovf_o      = r_ovf;

endmodule

// File: tb/tb_capsense_events.sv
// Directed bench for capsense_events: two instances (default config and DEB=1/DEPTH=2).
module tb_capsense_events;

  localparam logic [1:0] P = 2'd0;
  localparam logic [1:0] R = 2'd1;
  localparam logic [1:0] L = 2'd2;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] a_btn, b_btn;
  logic       a_smp, b_smp, a_rdy, b_rdy, a_clr, b_clr;
  logic [3:0] a_state, b_state;
  logic       a_val, b_val, a_ovf, b_ovf;
  logic [1:0] a_eb, a_et, b_eb, b_et;
  int         total = 0;
  int         bad = 0;

  always #5 clk = ~clk;

  capsense_events #(.N(4), .DEB(3), .LONG(12), .DEPTH(4)) u_a (
    .clk_i(clk), .rst_i(rst), .buttons_i(a_btn), .sample_i(a_smp), .state_o(a_state),
    .ev_valid_o(a_val), .ev_ready_i(a_rdy), .ev_btn_o(a_eb), .ev_type_o(a_et),
    .ovf_o(a_ovf), .clr_ovf_i(a_clr));

  capsense_events #(.N(4), .DEB(1), .LONG(12), .DEPTH(2)) u_b (
    .clk_i(clk), .rst_i(rst), .buttons_i(b_btn), .sample_i(b_smp), .state_o(b_state),
    .ev_valid_o(b_val), .ev_ready_i(b_rdy), .ev_btn_o(b_eb), .ev_type_o(b_et),
    .ovf_o(b_ovf), .clr_ovf_i(b_clr));

  task automatic poll_a(input logic [3:0] b);
    @(negedge clk); a_btn = b; a_smp = 1'b1;
    @(negedge clk); a_smp = 1'b0;
  endtask

  task automatic poll_b(input logic [3:0] b, input logic clr);
    @(negedge clk); b_btn = b; b_smp = 1'b1; b_clr = clr;
    @(negedge clk); b_smp = 1'b0; b_clr = 1'b0;
  endtask

  task automatic pop_a();
    a_rdy = 1'b1; @(negedge clk); a_rdy = 1'b0;
  endtask

  task automatic pop_b();
    b_rdy = 1'b1; @(negedge clk); b_rdy = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({a_state, a_val, a_eb, a_et, a_ovf} !== 10'd0) begin
      bad++; $display("FAIL reset_a got=%b want=0", {a_state, a_val, a_eb, a_et, a_ovf});
    end
    total++;
    if ({b_state, b_val, b_eb, b_et, b_ovf} !== 10'd0) begin
      bad++; $display("FAIL reset_b got=%b want=0", {b_state, b_val, b_eb, b_et, b_ovf});
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_clean();
    for (int s = 1; s <= 5; s++) begin
      poll_a(4'b0010);
      if (s == 3) begin
        total++;
        if ({a_val, a_state} !== 5'b0_0010) begin
          bad++; $display("FAIL clean_held got=%b want=00010", {a_val, a_state});
        end
        @(negedge clk);
        total++;
        if ({a_val, a_eb, a_et} !== {1'b1, 2'd1, P}) begin
          bad++; $display("FAIL clean_press got=%b want=%b", {a_val, a_eb, a_et}, {1'b1, 2'd1, P});
        end
        pop_a();
      end else if (s < 3) begin
        total++;
        if (a_state !== 4'b0000) begin
          bad++; $display("FAIL clean_pdeb_state s=%0d got=%b want=0000", s, a_state);
        end
      end
    end
    for (int s = 1; s <= 3; s++) begin
      poll_a(4'b0000);
      total++;
      if (a_state !== ((s < 3) ? 4'b0010 : 4'b0000)) begin
        bad++; $display("FAIL clean_rel_state s=%0d got=%b", s, a_state);
      end
    end
    @(negedge clk);
    total++;
    if ({a_val, a_eb, a_et} !== {1'b1, 2'd1, R}) begin
      bad++; $display("FAIL clean_release got=%b want=%b", {a_val, a_eb, a_et}, {1'b1, 2'd1, R});
    end
    pop_a();
    repeat (2) @(negedge clk);
    total++;
    if (a_val !== 1'b0) begin
      bad++; $display("FAIL clean_empty got=%b want=0", a_val);
    end
  endtask

  task automatic test_bounce();
    logic pat [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [4:0] exp;
    for (int s = 0; s < 6; s++) begin
      poll_a({3'b000, pat[s]});
      @(negedge clk);
      exp = (s == 5) ? {1'b1, 2'd0, P} : 5'd0;
      total++;
      if ({a_val, exp == 5'd0 ? 4'd0 : {a_eb, a_et}} !== exp) begin
        bad++; $display("FAIL bounce s=%0d got=%b want=%b", s + 1, {a_val, a_eb, a_et}, exp);
      end
      if (a_val) pop_a();
    end
    repeat (3) poll_a(4'b0000);
    @(negedge clk);
    total++;
    if ({a_val, a_eb, a_et} !== {1'b1, 2'd0, R}) begin
      bad++; $display("FAIL bounce_release got=%b want=%b", {a_val, a_eb, a_et}, {1'b1, 2'd0, R});
    end
    pop_a();
  endtask

  task automatic test_long();
    logic [4:0] exp;
    for (int s = 1; s <= 23; s++) begin
      poll_a((s == 8 || s > 20) ? 4'b0000 : 4'b0100);
      @(negedge clk);
      exp = 5'd0;
      if (s == 3)  exp = {1'b1, 2'd2, P};
      if (s == 13) exp = {1'b1, 2'd2, L};
      if (s == 23) exp = {1'b1, 2'd2, R};
      total++;
      if ({a_val, exp == 5'd0 ? 4'd0 : {a_eb, a_et}} !== exp) begin
        bad++; $display("FAIL long_seq s=%0d got=%b want=%b", s, {a_val, a_eb, a_et}, exp);
      end
      if (s == 8) begin
        total++;
        if (a_state !== 4'b0100) begin
          bad++; $display("FAIL long_dip_state got=%b want=0100", a_state);
        end
      end
      if (a_val) pop_a();
    end
  endtask

  task automatic test_simultaneous();
    a_rdy = 1'b0;
    poll_a(4'b1111);
    poll_a(4'b1111);
    a_rdy = 1'b1;
    poll_a(4'b1111);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      total++;
      if ({a_val, a_eb, a_et} !== {1'b1, k[1:0], P}) begin
        bad++; $display("FAIL simul_press k=%0d got=%b want=%b", k, {a_val, a_eb, a_et}, {1'b1, k[1:0], P});
      end
    end
    @(negedge clk);
    a_rdy = 1'b0;
    total++;
    if ({a_val, a_ovf} !== 2'b00) begin
      bad++; $display("FAIL simul_drained got=%b want=00", {a_val, a_ovf});
    end
    repeat (3) poll_a(4'b0000);
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      total++;
      if ({a_val, a_eb, a_et} !== {1'b1, k[1:0], R}) begin
        bad++; $display("FAIL simul_release k=%0d got=%b want=%b", k, {a_val, a_eb, a_et}, {1'b1, k[1:0], R});
      end
      pop_a();
    end
  endtask

  task automatic test_backpressure();
    b_rdy = 1'b0;
    poll_b(4'b1000, 1'b0);
    poll_b(4'b0000, 1'b0);
    poll_b(4'b1000, 1'b0);
    poll_b(4'b0000, 1'b0);
    total++;
    if (b_ovf !== 1'b0) begin
      bad++; $display("FAIL bp_no_ovf_yet got=%b want=0", b_ovf);
    end
    poll_b(4'b1000, 1'b0);
    total++;
    if (b_ovf !== 1'b1) begin
      bad++; $display("FAIL bp_ovf_set got=%b want=1", b_ovf);
    end
    repeat (2) begin
      @(negedge clk);
      total++;
      if ({b_val, b_eb, b_et} !== {1'b1, 2'd3, P}) begin
        bad++; $display("FAIL bp_head_stable got=%b want=%b", {b_val, b_eb, b_et}, {1'b1, 2'd3, P});
      end
    end
    b_clr = 1'b1; @(negedge clk); b_clr = 1'b0;
    total++;
    if (b_ovf !== 1'b0) begin
      bad++; $display("FAIL bp_ovf_clear got=%b want=0", b_ovf);
    end
    poll_b(4'b0000, 1'b1);
    total++;
    if (b_ovf !== 1'b1) begin
      bad++; $display("FAIL bp_set_beats_clr got=%b want=1", b_ovf);
    end
    for (int k = 0; k < 4; k++) begin
      total++;
      if ({b_val, b_eb, b_et} !== {1'b1, 2'd3, (k % 2 == 1) ? R : P}) begin
        bad++; $display("FAIL bp_drain k=%0d got=%b want=%b", k, {b_val, b_eb, b_et},
                        {1'b1, 2'd3, (k % 2 == 1) ? R : P});
      end
      pop_b();
    end
    repeat (2) @(negedge clk);
    total++;
    if (b_val !== 1'b0) begin
      bad++; $display("FAIL bp_empty got=%b want=0", b_val);
    end
  endtask

  task automatic test_reset_mid();
    a_rdy = 1'b0;
    repeat (12) poll_a(4'b0001);
    repeat (2) @(negedge clk);
    total++;
    if ({a_state, a_val, a_eb, a_et} !== {4'b0001, 1'b1, 2'd0, P}) begin
      bad++; $display("FAIL rstmid_before got=%b want=%b", {a_state, a_val, a_eb, a_et}, {4'b0001, 1'b1, 2'd0, P});
    end
    rst = 1'b1;
    @(negedge clk);
    total++;
    if ({a_state, a_val, a_eb, a_et, a_ovf} !== 10'd0) begin
      bad++; $display("FAIL rstmid_outputs got=%b want=0", {a_state, a_val, a_eb, a_et, a_ovf});
    end
    rst = 1'b0;
    a_btn = 4'b0000;
    repeat (4) poll_a(4'b0000);
    repeat (3) @(negedge clk);
    total++;
    if ({a_state, a_val, a_ovf} !== 6'd0) begin
      bad++; $display("FAIL rstmid_no_release got=%b want=0", {a_state, a_val, a_ovf});
    end
  endtask

  initial begin
    rst = 1'b1;
    a_btn = '0; a_smp = 1'b0; a_rdy = 1'b0; a_clr = 1'b0;
    b_btn = '0; b_smp = 1'b0; b_rdy = 1'b0; b_clr = 1'b0;
    test_reset();
    test_clean();
    test_bounce();
    test_long();
    test_simultaneous();
    test_backpressure();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule
